// File: rtl/clk_ratio_detector_pkg.sv
// -----------------------------------------------------------------------------
// clk_ratio_pkg
// Shared definitions for the clock-ratio detector:
//   - SEL_DIV* : ratio encodings, identical to the clock-divider mux select
//   - state_e  : detector FSM states
//   - decode_period() : maps a measured period to {legal, sel}
// No ports (package).
// -----------------------------------------------------------------------------
package clk_ratio_pkg;

  localparam logic [1:0] SEL_DIV2 = 2'b00;
  localparam logic [1:0] SEL_DIV4 = 2'b01;
  localparam logic [1:0] SEL_DIV8 = 2'b10;
  localparam logic [1:0] SEL_DIV3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MEASURE = 2'b01,
    ST_TRACK   = 2'b10,
    ST_LOCKED  = 2'b11
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] sel;
  } ratio_dec_t;

  // Only periods the divider can actually produce are legal; sel is don't-care otherwise.
  function automatic ratio_dec_t decode_period(input logic [31:0] p);
    ratio_dec_t d;
    d.legal = 1'b1;
    d.sel   = SEL_DIV2;
    case (p)
      32'd2:   d.sel = SEL_DIV2;
      32'd4:   d.sel = SEL_DIV4;
      32'd8:   d.sel = SEL_DIV8;
      32'd3:   d.sel = SEL_DIV3;
      default: begin
        d.legal = 1'b0;
        d.sel   = SEL_DIV2;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/clk_ratio_detector_if.sv
// -----------------------------------------------------------------------------
// clk_ratio_detector_if
// Bundles the divided clock under test and the detector results.
//   dclk_in    : divided clock under test (master -> slave)
//   period     : last measured period in clk cycles (CW bits)
//   period_vld : one-cycle pulse when period updates
//   sel_det    : decoded ratio 00=/2 01=/4 10=/8 11=/3
//   ratio_err  : last period illegal or input lost
//   locked     : ratio stable for LOCK_CNT periods
// slave modport = detector, master modport = whoever drives dclk_in / reads results.
// -----------------------------------------------------------------------------
interface clk_ratio_detector_if #(
  parameter int CW = 8
);
  logic          dclk_in;
  logic [CW-1:0] period;
  logic          period_vld;
  logic [1:0]    sel_det;
  logic          ratio_err;
  logic          locked;

  modport master (
    output dclk_in,
    input  period, period_vld, sel_det, ratio_err, locked
  );

  modport slave (
    input  dclk_in,
    output period, period_vld, sel_det, ratio_err, locked
  );
endinterface

// File: rtl/clk_ratio_detector_rise_det.sv
// -----------------------------------------------------------------------------
// clk_rise_det
// Samples dclk_in on posedge clk and flags a rising edge for one cycle.
//   clk, rst_n : clock, async active-low reset
//   din_i      : divided clock under test
//   rise_o     : high for one cycle after a 0->1 transition has been sampled
// Macro CLK_RATIO_SYNC_EN: adds two reset-to-0 synchroniser flops ahead of the
// sample flop for an input from an unrelated domain (every response 2 cycles later).
// -----------------------------------------------------------------------------
module clk_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o
);

  logic samp_in_s;
  logic s_q;
  logic s_dly_q;

`ifdef CLK_RATIO_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser ahead of the sample flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din_i};
    end
  end

  assign samp_in_s = sync_q[1];
`else
  assign samp_in_s = din_i;
`endif

  // Sample flop and its one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= samp_in_s;
      s_dly_q <= s_q;
    end
  end

  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/clk_ratio_detector.sv
// -----------------------------------------------------------------------------
// clk_ratio_detector
// Monitors a divided clock: measures clk cycles between rising edges, recovers
// the divider select (/2,/4,/8,/3), flags illegal periods / lost input and
// asserts locked after LOCK_CNT consecutive equal legal periods.
// Ports:
//   clk   : system clock (posedge)
//   rst_n : async active-low reset
//   bus   : clk_ratio_detector_if.slave (dclk_in in; period, period_vld,
//           sel_det, ratio_err, locked out; all outputs registered)
// Parameters: CW (counter/period width), LOCK_CNT (>=2), TIMEOUT (< 2**CW).
// Macro CLK_RATIO_SYNC_EN: see clk_rise_det (extra 2-flop sync on dclk_in).
// -----------------------------------------------------------------------------
module clk_ratio_detector
  import clk_ratio_pkg::*;
#(
  parameter int CW       = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  clk_ratio_detector_if.slave bus
);

  localparam int            MW        = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic          rise_s;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period_q;
  logic          period_vld_q;
  logic [1:0]    sel_q;
  logic          err_q;
  logic          locked_q;
  logic [MW-1:0] match_q;

  ratio_dec_t    dec_s;
  logic          same_s;
  logic          tmo_s;
  logic [MW-1:0] match_inc_s;

  clk_rise_det u_rise_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (bus.dclk_in),
    .rise_o (rise_s)
  );

  // cnt_q holds the clk cycles since the last rise, i.e. the period a rise now would report
  always_comb begin
    dec_s       = decode_period(32'(cnt_q));
    same_s      = (cnt_q == period_q) && dec_s.legal;
    tmo_s       = (cnt_q == TIMEOUT_C) && !rise_s;
    match_inc_s = match_q + MW'(1);
  end

  // Period counter, lock FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      sel_q        <= SEL_DIV2;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      match_q      <= '0;
    end else begin
      period_vld_q <= 1'b0;

      // Saturates so a lost input can never wrap into a plausible period
      if (rise_s) begin
        cnt_q <= CW'(1);
      end else if (cnt_q != TIMEOUT_C) begin
        cnt_q <= cnt_q + CW'(1);
      end

      // Any rise after arming reports a period; sel only follows legal ones
      if (rise_s && (state_q != ST_IDLE)) begin
        period_q     <= cnt_q;
        period_vld_q <= 1'b1;
        err_q        <= ~dec_s.legal;
        if (dec_s.legal) begin
          sel_q <= dec_s.sel;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            state_q <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise_s && dec_s.legal) begin
            state_q <= ST_TRACK;
            match_q <= MW'(1);
          end else if (tmo_s) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (rise_s) begin
            if (same_s) begin
              if (match_inc_s == MW'(LOCK_CNT)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
              match_q <= match_inc_s;
            end else if (dec_s.legal) begin
              match_q <= MW'(1);
            end else begin
              state_q <= ST_MEASURE;
              match_q <= '0;
            end
          end else if (tmo_s) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            match_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (rise_s && !same_s) begin
            locked_q <= 1'b0;
            state_q  <= dec_s.legal ? ST_TRACK : ST_MEASURE;
            match_q  <= dec_s.legal ? MW'(1) : '0;
          end else if (tmo_s) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            match_q  <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
          match_q  <= '0;
        end
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.sel_det    = sel_q;
  assign bus.ratio_err  = err_q;
  assign bus.locked     = locked_q;

endmodule
